// File: rtl/connect4_board_if.sv
// Game-state bundle between the button logic, the connect4_board and the grid renderer.
// master drives drop requests and new_game; slave (the board) returns status and occupancy maps.
interface connect4_board_if #(
    parameter int NUM_ROWS = 6,
    parameter int NUM_COLS = 7
);
    localparam int NUM_CELLS = NUM_ROWS * NUM_COLS;
    localparam int CNT_W     = $clog2(NUM_CELLS + 1);

    logic                 new_game;
    logic                 drop_req;
    logic [2:0]           col_sel;
    logic                 busy;
    logic                 drop_ack;
    logic                 drop_err;
    logic [NUM_CELLS-1:0] red_player;
    logic [NUM_CELLS-1:0] yellow_player;
    logic                 is_red_turn;
    logic [CNT_W-1:0]     piece_count;
    logic                 board_full;
    logic                 turn_timeout;

    modport master (
        output new_game, drop_req, col_sel,
        input  busy, drop_ack, drop_err, red_player, yellow_player,
               is_red_turn, piece_count, board_full, turn_timeout
    );

    modport slave (
        input  new_game, drop_req, col_sel,
        output busy, drop_ack, drop_err, red_player, yellow_player,
               is_red_turn, piece_count, board_full, turn_timeout
    );
endinterface

// File: rtl/connect4_board.sv
// Connect-4 board state: occupancy maps, turn flag and gravity scan (bottom row upward, one row per cycle).
// Latency: ack 2..7 edges after the sampling edge, immediate reject 1 edge; requests while busy are dropped.
// Optional CONNECT4_TURN_TIMEOUT_EN builds the idle turn-pass counter.
module connect4_board #(
    parameter int NUM_ROWS       = 6,
    parameter int NUM_COLS       = 7,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic             clk,
    input  logic             reset,
    connect4_board_if.slave  bus
);
    localparam int NUM_CELLS = NUM_ROWS * NUM_COLS;
    localparam int IDX_W     = $clog2(NUM_CELLS);
    localparam int ROW_W     = $clog2(NUM_ROWS);
    localparam int CNT_W     = $clog2(NUM_CELLS + 1);
    localparam int COL_W     = 3;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CELLS);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               state_q;
    logic [NUM_CELLS-1:0] red_q;
    logic [NUM_CELLS-1:0] yel_q;
    logic                 turn_q;
    logic [CNT_W-1:0]     count_q;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;
    logic                 ack_q;
    logic                 err_q;

    logic [IDX_W-1:0]     cell_idx;
    logic [NUM_CELLS-1:0] cell_mask;
    logic                 cell_occ;
    logic                 board_full;
    logic                 bad_col;
    logic [NUM_CELLS-1:0] red_d;
    logic [NUM_CELLS-1:0] yel_d;
    logic [CNT_W-1:0]     count_d;

    always_comb begin
        cell_idx  = IDX_W'(row_q) * IDX_W'(NUM_COLS) + IDX_W'(col_q);
        cell_mask = NUM_CELLS'(1) << cell_idx;
        cell_occ  = |((red_q | yel_q) & cell_mask);
        board_full = (count_q == CNT_FULL);
        bad_col    = (bus.col_sel > COL_LAST);
        // Only the mover's map gains the landing cell.
        red_d   = turn_q ? (red_q | cell_mask) : red_q;
        yel_d   = turn_q ? yel_q : (yel_q | cell_mask);
        count_d = count_q + CNT_W'(1);
    end

`ifdef CONNECT4_TURN_TIMEOUT_EN
    localparam logic [27:0] TMO_LAST = 28'(TIMEOUT_CYCLES - 1);
    logic [27:0] tmo_cnt_q;
    logic        tmo_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!reset || bus.new_game) begin
            state_q <= IDLE;
            red_q   <= '0;
            yel_q   <= '0;
            turn_q  <= 1'b1;
            count_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef CONNECT4_TURN_TIMEOUT_EN
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
`ifdef CONNECT4_TURN_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.drop_req) begin
                        if (bad_col || board_full) begin
                            err_q <= 1'b1;
                        end else begin
                            col_q   <= bus.col_sel;
                            row_q   <= ROW_LAST;
                            state_q <= SCAN;
                        end
                    end
`ifdef CONNECT4_TURN_TIMEOUT_EN
                    // A request in the expiry cycle wins; the pass is discarded.
                    if (bus.drop_req) begin
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        if (!board_full) begin
                            turn_q    <= ~turn_q;
                            tmo_q     <= 1'b1;
                            tmo_cnt_q <= '0;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 28'd1;
                    end
`endif
                end
                SCAN: begin
`ifdef CONNECT4_TURN_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    if (!cell_occ) begin
                        red_q   <= red_d;
                        yel_q   <= yel_d;
                        turn_q  <= ~turn_q;
                        count_q <= count_d;
                        ack_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (row_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        row_q <= row_q - ROW_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state_q != IDLE);
    assign bus.drop_ack      = ack_q;
    assign bus.drop_err      = err_q;
    assign bus.red_player    = red_q;
    assign bus.yellow_player = yel_q;
    assign bus.is_red_turn   = turn_q;
    assign bus.piece_count   = count_q;
    assign bus.board_full    = board_full;
`ifdef CONNECT4_TURN_TIMEOUT_EN
    assign bus.turn_timeout  = tmo_q;
`else
    assign bus.turn_timeout  = 1'b0;
`endif

    a_no_overlap: assert property (@(posedge clk) disable iff (!reset)
        (red_q & yel_q) == '0);
    a_ack_err_excl: assert property (@(posedge clk) disable iff (!reset)
        !(ack_q && err_q));
    a_col_stable: assert property (@(posedge clk) disable iff (!reset)
        (state_q == SCAN) && $past(state_q == SCAN) |-> col_q == $past(col_q));
endmodule

// File: tb/tb_connect4_board.sv
// Directed bench for connect4_board: gravity, rejects, ignored requests, full board, new_game abort, idle timeout.
module tb_connect4_board;
    localparam int NR = 6;
    localparam int NC = 7;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    connect4_board_if #(.NUM_ROWS(NR), .NUM_COLS(NC)) bus ();

    connect4_board #(.NUM_ROWS(NR), .NUM_COLS(NC), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bit_of(input int r, input int c);
        return r * NC + c;
    endfunction

    // Called at a negedge with the board idle; returns at the negedge where ack/err appears (or the bound expires).
    task automatic do_drop(input logic [2:0] c, output int edges, output logic got_ack,
                           output logic got_err, output logic saw_busy);
        bus.drop_req = 1'b1;
        bus.col_sel  = c;
        @(negedge clk);
        bus.drop_req = 1'b0;
        edges    = 1;
        saw_busy = 1'b0;
        while (edges < 20) begin
            saw_busy = saw_busy | bus.busy;
            if (bus.drop_ack || bus.drop_err) break;
            @(negedge clk);
            edges++;
        end
        got_ack = bus.drop_ack;
        got_err = bus.drop_err;
    endtask

    task automatic pulse_new_game();
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.new_game = 1'b0;
        bus.drop_req = 1'b0;
        bus.col_sel  = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        vectors++;
        if (bus.red_player !== 42'd0 || bus.yellow_player !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_maps: red=%h yellow=%h want 0/0", bus.red_player, bus.yellow_player);
        end
        vectors++;
        if (bus.is_red_turn !== 1'b1 || bus.piece_count !== 6'd0 || bus.board_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: turn=%b count=%0d full=%b want 1/0/0",
                     bus.is_red_turn, bus.piece_count, bus.board_full);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.drop_ack !== 1'b0 || bus.drop_err !== 1'b0 || bus.turn_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses: busy=%b ack=%b err=%b tmo=%b want 0000",
                     bus.busy, bus.drop_ack, bus.drop_err, bus.turn_timeout);
        end
    endtask

    task automatic test_first_drop();
        int edges; logic a, e, b;
        logic [41:0] exp_red;
        exp_red = '0;
        exp_red[38] = 1'b1;
        do_drop(3'd3, edges, a, e, b);
        vectors++;
        if (a !== 1'b1 || e !== 1'b0 || edges != 2 || b !== 1'b1) begin
            miscompares++;
            $display("FAIL first_latency: ack=%b err=%b edges=%0d busy=%b want 1/0/2/1", a, e, edges, b);
        end
        vectors++;
        if (bus.red_player !== exp_red || bus.yellow_player !== 42'd0) begin
            miscompares++;
            $display("FAIL first_maps: red=%h yellow=%h want %h/0", bus.red_player, bus.yellow_player, exp_red);
        end
        vectors++;
        if (bus.is_red_turn !== 1'b0 || bus.piece_count !== 6'd1) begin
            miscompares++;
            $display("FAIL first_turn: turn=%b count=%0d want 0/1", bus.is_red_turn, bus.piece_count);
        end
    endtask

    task automatic test_column_fill();
        int edges; logic a, e, b;
        logic [41:0] exp_red, exp_yel;
        exp_red = '0;
        exp_yel = '0;
        exp_red[35] = 1'b1; exp_red[21] = 1'b1; exp_red[7] = 1'b1;
        exp_yel[28] = 1'b1; exp_yel[14] = 1'b1; exp_yel[0] = 1'b1;
        pulse_new_game();
        for (int k = 0; k < NR; k++) begin
            do_drop(3'd0, edges, a, e, b);
            vectors++;
            if (a !== 1'b1 || edges != 2 + k) begin
                miscompares++;
                $display("FAIL col0_drop%0d: ack=%b edges=%0d want 1/%0d", k, a, edges, 2 + k);
            end
        end
        vectors++;
        if (bus.red_player !== exp_red || bus.yellow_player !== exp_yel) begin
            miscompares++;
            $display("FAIL col0_maps: red=%h yellow=%h want %h/%h",
                     bus.red_player, bus.yellow_player, exp_red, exp_yel);
        end
        do_drop(3'd0, edges, a, e, b);
        vectors++;
        if (e !== 1'b1 || a !== 1'b0 || edges != 7) begin
            miscompares++;
            $display("FAIL col0_full_err: err=%b ack=%b edges=%0d want 1/0/7", e, a, edges);
        end
        vectors++;
        if (bus.red_player !== exp_red || bus.yellow_player !== exp_yel ||
            bus.is_red_turn !== 1'b1 || bus.piece_count !== 6'd6) begin
            miscompares++;
            $display("FAIL col0_after_err: turn=%b count=%0d maps changed=%b want 1/6/0", bus.is_red_turn,
                     bus.piece_count, (bus.red_player !== exp_red) || (bus.yellow_player !== exp_yel));
        end
    endtask

    task automatic test_bad_col();
        int edges; logic a, e, b;
        do_drop(3'd7, edges, a, e, b);
        vectors++;
        if (e !== 1'b1 || a !== 1'b0 || edges != 1 || b !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_col: err=%b ack=%b edges=%0d busy=%b want 1/0/1/0", e, a, edges, b);
        end
        vectors++;
        if (bus.piece_count !== 6'd6 || bus.is_red_turn !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_col_state: count=%0d turn=%b want 6/1", bus.piece_count, bus.is_red_turn);
        end
    endtask

    task automatic test_req_during_scan();
        int edges; logic a, e, b;
        int acks, errs;
        logic [41:0] exp_red, exp_yel;
        exp_red = '0; exp_yel = '0;
        exp_red[bit_of(5, 4)] = 1'b1; exp_red[bit_of(3, 4)] = 1'b1;
        exp_yel[bit_of(4, 4)] = 1'b1; exp_yel[bit_of(2, 4)] = 1'b1;
        pulse_new_game();
        for (int k = 0; k < 3; k++) do_drop(3'd4, edges, a, e, b);
        bus.drop_req = 1'b1;
        bus.col_sel  = 3'd4;
        @(negedge clk);
        bus.drop_req = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL scan_busy: busy=%b want 1", bus.busy);
        end
        @(negedge clk);
        bus.drop_req = 1'b1;
        bus.col_sel  = 3'd1;
        @(negedge clk);
        bus.drop_req = 1'b0;
        acks = 0; errs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.drop_ack === 1'b1) acks++;
            if (bus.drop_err === 1'b1) errs++;
        end
        vectors++;
        if (acks != 1 || errs != 0) begin
            miscompares++;
            $display("FAIL scan_ignore: acks=%0d errs=%0d want 1/0", acks, errs);
        end
        vectors++;
        if (bus.red_player !== exp_red || bus.yellow_player !== exp_yel || bus.piece_count !== 6'd4) begin
            miscompares++;
            $display("FAIL scan_maps: red=%h yellow=%h count=%0d want %h/%h/4",
                     bus.red_player, bus.yellow_player, bus.piece_count, exp_red, exp_yel);
        end
    endtask

    task automatic test_board_full();
        int edges; logic a, e, b;
        int n;
        logic [41:0] exp_red, exp_yel;
        exp_red = '0; exp_yel = '0;
        pulse_new_game();
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < NR; k++) begin
                n = c * NR + k;
                if (n % 2 == 0) exp_red[bit_of(NR - 1 - k, c)] = 1'b1;
                else            exp_yel[bit_of(NR - 1 - k, c)] = 1'b1;
                do_drop(3'(c), edges, a, e, b);
                vectors++;
                if (a !== 1'b1 || edges != 2 + k) begin
                    miscompares++;
                    $display("FAIL fill_c%0d_k%0d: ack=%b edges=%0d want 1/%0d", c, k, a, edges, 2 + k);
                end
            end
        end
        vectors++;
        if (bus.board_full !== 1'b1 || bus.piece_count !== 6'd42 || bus.is_red_turn !== 1'b1) begin
            miscompares++;
            $display("FAIL full_state: full=%b count=%0d turn=%b want 1/42/1",
                     bus.board_full, bus.piece_count, bus.is_red_turn);
        end
        vectors++;
        if (bus.red_player !== exp_red || bus.yellow_player !== exp_yel) begin
            miscompares++;
            $display("FAIL full_maps: red=%h yellow=%h want %h/%h",
                     bus.red_player, bus.yellow_player, exp_red, exp_yel);
        end
        do_drop(3'd3, edges, a, e, b);
        vectors++;
        if (e !== 1'b1 || a !== 1'b0 || edges != 1 || b !== 1'b0) begin
            miscompares++;
            $display("FAIL full_reject: err=%b ack=%b edges=%0d busy=%b want 1/0/1/0", e, a, edges, b);
        end
    endtask

    task automatic test_new_game_mid_scan();
        int edges; logic a, e, b;
        int acks, errs;
        pulse_new_game();
        do_drop(3'd2, edges, a, e, b);
        do_drop(3'd2, edges, a, e, b);
        bus.drop_req = 1'b1;
        bus.col_sel  = 3'd2;
        @(negedge clk);
        bus.drop_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1 || bus.drop_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ng_pre: busy=%b ack=%b want 1/0", bus.busy, bus.drop_ack);
        end
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.drop_ack !== 1'b0 || bus.drop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ng_abort: busy=%b ack=%b err=%b want 0/0/0", bus.busy, bus.drop_ack, bus.drop_err);
        end
        vectors++;
        if (bus.red_player !== 42'd0 || bus.yellow_player !== 42'd0 ||
            bus.is_red_turn !== 1'b1 || bus.piece_count !== 6'd0) begin
            miscompares++;
            $display("FAIL ng_clear: red=%h yellow=%h turn=%b count=%0d want 0/0/1/0",
                     bus.red_player, bus.yellow_player, bus.is_red_turn, bus.piece_count);
        end
        acks = 0; errs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.drop_ack === 1'b1) acks++;
            if (bus.drop_err === 1'b1) errs++;
        end
        vectors++;
        if (acks != 0 || errs != 0) begin
            miscompares++;
            $display("FAIL ng_quiet: acks=%0d errs=%0d want 0/0", acks, errs);
        end
    endtask

`ifdef CONNECT4_TURN_TIMEOUT_EN
    task automatic test_timeout();
        int early; int late;
        logic [41:0] exp_yel;
        exp_yel = '0;
        exp_yel[bit_of(5, 0)] = 1'b1;
        pulse_new_game();
        early = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.turn_timeout === 1'b1) early++;
        end
        @(negedge clk);
        vectors++;
        if (early != 0 || bus.turn_timeout !== 1'b1 || bus.is_red_turn !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_expire: early=%0d tmo=%b turn=%b want 0/1/0", early, bus.turn_timeout, bus.is_red_turn);
        end
        for (int i = 0; i < 15; i++) @(negedge clk);
        bus.drop_req = 1'b1;
        bus.col_sel  = 3'd0;
        @(negedge clk);
        bus.drop_req = 1'b0;
        late = (bus.turn_timeout === 1'b1) ? 1 : 0;
        @(negedge clk);
        if (bus.turn_timeout === 1'b1) late++;
        vectors++;
        if (late != 0 || bus.drop_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_vs_drop: tmo_pulses=%0d ack=%b want 0/1", late, bus.drop_ack);
        end
        vectors++;
        if (bus.yellow_player !== exp_yel || bus.red_player !== 42'd0 || bus.is_red_turn !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_maps: red=%h yellow=%h turn=%b want 0/%h/1",
                     bus.red_player, bus.yellow_player, bus.is_red_turn, exp_yel);
        end
    endtask
`else
    task automatic test_timeout();
        int pulses;
        pulse_new_game();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.turn_timeout !== 1'b0) pulses++;
        end
        vectors++;
        if (pulses != 0 || bus.is_red_turn !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_disabled: pulses=%0d turn=%b want 0/1", pulses, bus.is_red_turn);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_first_drop();
        test_column_fill();
        test_bad_col();
        test_req_during_scan();
        test_board_full();
        test_new_game_mid_scan();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/connect4_board.md
Name: connect4_board

Overview:
- Game-state stage directly upstream of the VGA grid renderer. It owns the 6x7 Connect-4 occupancy maps and the turn flag, and applies gravity when a player drops a piece into a column.
- It drives red_player, yellow_player and is_red_turn straight into the renderer, and reports accept/reject back to the input/button logic.

Parameters:
- NUM_ROWS, 6, board rows; row 0 is top (pixel_y small), row NUM_ROWS-1 is bottom.
- NUM_COLS, 7, board columns; column 0 is leftmost.
- TIMEOUT_CYCLES, 250000000, idle cycles before a forced turn pass (10 s at 25 MHz); used only with TURN_TIMEOUT_EN.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-low reset.
- new_game  in  1  synchronous clear of board, turn and counters; 1-cycle pulse or level.
- drop_req  in  1  request to drop the current player's piece; sampled only in IDLE.
- col_sel  in  3  target column 0..NUM_COLS-1.
- busy  out  1  high whenever the FSM is not in IDLE.
- drop_ack  out  1  1-cycle pulse: piece placed; maps already updated in this cycle.
- drop_err  out  1  1-cycle pulse: request rejected (column full, col_sel>=NUM_COLS, or board full).
- red_player  out  42  red occupancy; bit index = row*NUM_COLS+col.
- yellow_player  out  42  yellow occupancy; same mapping.
- is_red_turn  out  1  1 = red moves next.
- piece_count  out  6  number of pieces on the board, 0..42.
- board_full  out  1  high when piece_count==42.
- turn_timeout  out  1  1-cycle pulse on forced turn pass; constant 0 without TURN_TIMEOUT_EN.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Both maps =0, is_red_turn=1, piece_count=0, all pulse outputs=0, FSM=IDLE, timeout counter=0.
- new_game==1:
  - Same effect as reset. Priority over every other event.
  - Aborts any scan in progress. No ack or err is issued.
- FSM states: IDLE, SCAN.
  - All outputs are registered; drop_ack and drop_err default to 0 every cycle.
- IDLE with drop_req==1:
  - If col_sel>=NUM_COLS or board_full: drop_err=1 next cycle, stay IDLE, no state change.
  - Otherwise: latch col_sel into col_q, set row_q=NUM_ROWS-1, go to SCAN.
- SCAN, one row per cycle. Cell occupied = red_player|yellow_player at row_q*NUM_COLS+col_q.
  - Cell empty: set that bit in the current player's map, toggle is_red_turn, piece_count+=1, drop_ack=1, go to IDLE.
  - Cell occupied and row_q==0: drop_err=1, turn unchanged, go to IDLE.
  - Cell occupied and row_q>0: row_q-=1.
- Latency, counted from the edge sampling drop_req:
  - drop_ack is visible after 2+(NUM_ROWS-1-r) edges for landing row r (2 edges for an empty column, 7 for row 0).
  - A full column gives drop_err after 7 edges.
  - An immediate reject (bad column or full board) gives drop_err after 1 edge.
- drop_req while busy is ignored, not queued. A level-held drop_req re-triggers on every return to IDLE; the caller must edge-detect.
- Exactly one map bit changes per ack. A bit is never set in both maps. Maps never clear except on reset/new_game.
- col_q is stable during SCAN; col_sel changes while busy have no effect.
- board_full is combinational from piece_count. After the 42nd piece, every further request yields drop_err.

Optional Feature:
- Macro: CONNECT4_TURN_TIMEOUT_EN.
- When defined:
  - A 28-bit counter increments each cycle in IDLE.
  - It clears on drop_ack, new_game, reset, and while busy.
  - On reaching TIMEOUT_CYCLES-1 in IDLE with board_full==0: toggle is_red_turn, pulse turn_timeout for 1 cycle, clear the counter; maps are unchanged.
  - If drop_req is sampled in the same cycle as the expiry, the request is accepted first and the timeout is discarded.
- When undefined: no counter is built, turn_timeout is tied 0, and the turn changes only on drop_ack.

Test Plan:
- Reset, then drop_req col_sel=3 -> drop_ack 2 cycles later; red_player[38]=1 (row5,col3); is_red_turn=0; piece_count=1.
- Six drops in col 0, alternating players -> rows 5..0 filled, red bits 35,21,7 and yellow bits 28,14,0. A 7th drop in col 0 -> drop_err after 7 cycles; maps and turn unchanged.
- drop_req col_sel=7 -> drop_err after 1 cycle, busy never asserts. drop_req pulsed during SCAN -> ignored, only one ack.
- Fill all 42 cells -> board_full=1, piece_count=42; next request -> drop_err after 1 cycle.
- new_game asserted mid-SCAN (col 2, third scan cycle) -> maps=0, is_red_turn=1, no ack/err, busy=0 next cycle.
- With CONNECT4_TURN_TIMEOUT_EN and TIMEOUT_CYCLES=16: idle 16 cycles -> turn_timeout pulse, is_red_turn toggles. Drop on the expiry cycle -> ack only, no timeout pulse.
